// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, 8-bit MSB-first, oversampled in the clock domain.
// Latency: a received byte shows on rx_valid SYNC_STAGES+2 clocks after its 8th SCK rise
//   reaches the first synchronizer flop.
// Backpressure: tx is a 1-deep hold register (tx_ready = empty). An unread rx buffer drops
//   new bytes and pulses rx_overrun. An empty hold at a byte boundary sends 0xFF and
//   pulses tx_underrun.
// Optional feature: define SPI_SLAVE_RXFIFO_EN for a 4-entry rx FIFO. Without it the rx
//   buffer is a single register.
// Ports:
//   clock, reset            : system clock, async active-high reset
//   io_SCK/io_SS/io_MOSI    : SPI inputs (SCK idle low, SS active low)
//   io_MISO                 : SPI output, 0 while SS is high
//   tx_data/valid/ready     : byte to return to the master
//   rx_data/valid/ready     : received byte
//   rx_overrun/tx_underrun  : one-cycle error pulses
//   busy                    : frame active
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_SCK,
  input  logic       io_SS,
  input  logic       io_MOSI,
  output logic       io_MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output logic       busy
);

  // Synchronizers. SS resets to 0 (not its idle 1) on purpose.
  // If reset releases mid-frame, no false SS fall is seen.
  // The engine then stays idle until SS is observed high and falls again.
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_d, ss_d, mosi_d;
  logic sck_rise, sck_fall, ss_rise, ss_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b0;
      mosi_d    <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], io_SCK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], io_SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], io_MOSI};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
      // Edge strobes are registered, so the frame engine sees one clean pulse per edge.
      sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_d;
      sck_fall  <= ~sck_sync[SYNC_STAGES-1] & sck_d;
      ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_d;
      ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_d;
    end
  end

  // Frame engine
  logic       active;
  logic [2:0] bit_cnt;
  logic       byte_end;   // 8th rise seen; the next SCK fall is a byte boundary
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold;
  logic       hold_full;
  logic       push;
  logic [7:0] push_byte;
  logic       boundary;

  // An SS rise takes priority over everything, including a coincident SCK edge.
  assign boundary = !ss_rise && (ss_fall || (active && sck_fall && byte_end));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active      <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_end    <= 1'b0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      hold        <= 8'd0;
      hold_full   <= 1'b0;
      push        <= 1'b0;
      push_byte   <= 8'd0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      push        <= 1'b0;

      // Writes are accepted only while empty, and loads only happen while full.
      // The two assignments to hold_full therefore never collide.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (boundary) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift    <= 8'hFF;
          tx_underrun <= 1'b1;
        end
      end

      if (ss_rise) begin
        // Abort: drop the partial byte and the shifter. The hold register is kept.
        active   <= 1'b0;
        bit_cnt  <= 3'd0;
        byte_end <= 1'b0;
        rx_shift <= 7'd0;
        tx_shift <= 8'd0;
      end else if (ss_fall) begin
        active   <= 1'b1;
        bit_cnt  <= 3'd0;
        byte_end <= 1'b0;
        rx_shift <= 7'd0;
      end else if (active) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_d};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            push      <= 1'b1;
            push_byte <= {rx_shift, mosi_d};
            byte_end  <= 1'b1;
          end
        end else if (sck_fall) begin
          if (byte_end) byte_end <= 1'b0;
          else          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign io_MISO  = active & tx_shift[7];
  assign tx_ready = ~hold_full;
  assign busy     = active;

  // Rx buffer
  logic pop;
  assign pop = rx_valid & rx_ready;

`ifdef SPI_SLAVE_RXFIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       wr_en;

  // A pop on the same clock frees a slot, so a push at full still lands.
  assign wr_en = push && ((count != 3'd4) || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= push && !wr_en;
      if (wr_en) begin
        fifo_mem[wr_ptr] <= push_byte;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign rx_data  = fifo_mem[rd_ptr];
  assign rx_valid = (count != 3'd0);
`else
  logic [7:0] rx_reg;
  logic       rx_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_reg     <= 8'd0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (push && (!rx_full || pop)) begin
        rx_reg  <= push_byte;
        rx_full <= 1'b1;
      end else if (push) begin
        rx_overrun <= 1'b1;       // full and not popped: keep the old byte
      end else if (pop) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign rx_data  = rx_reg;
  assign rx_valid = rx_full;
`endif

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, setting the synchronizer depth on io_SCK, io_SS and io_MOSI (legal range 2..3).
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; every flop uses its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port io_SCK, input, 1 bit: SPI serial clock from the external master (CPOL=0).
REQ-005 SHALL have port io_SS, input, 1 bit: active-low slave select.
REQ-006 SHALL have port io_MOSI, input, 1 bit: master-out data.
REQ-007 SHALL have port io_MISO, output, 1 bit: slave-out data, MSB first.
REQ-008 SHALL have port tx_data, input, 8 bits: next byte to return to the master.
REQ-009 SHALL have port tx_valid, input, 1 bit, and port tx_ready, output, 1 bit: handshake; a byte is accepted on a clock where both are 1.
REQ-010 SHALL have port rx_data, output, 8 bits, and port rx_valid, output, 1 bit: received byte.
REQ-011 SHALL have port rx_ready, input, 1 bit: consumer pops rx_data on a clock where rx_valid and rx_ready are both 1.
REQ-012 SHALL have ports rx_overrun, tx_underrun and busy, each output, 1 bit; the first two are single-cycle pulses, and busy is 1 while a frame is active.

Function
REQ-013 SHALL implement SPI mode 0, 8-bit MSB-first: sample MOSI on synchronized SCK rise, update MISO on synchronized SCK fall; requires clock >= 4x SCK.
REQ-014 SHALL detect SCK and SS edges in the clock domain only, after the SYNC_STAGES synchronizers; io_SCK SHALL NOT clock any flop.
REQ-015 SHALL keep a 1-deep tx holding register; tx_ready = hold register empty.
REQ-016 SHALL, at a byte boundary, load the tx shifter from the hold register and empty it; with the hold register empty it loads 0xFF and pulses tx_underrun for one cycle. A byte boundary is the SS falling edge, or the SCK falling edge after the 8th rise while SS stays low.
REQ-017 SHALL drive io_MISO = tx shifter bit 7 while SS is low, shift left on each non-boundary SCK fall, and drive 0 while SS is high.
REQ-018 SHALL count SCK rises 0..7 with a 3-bit counter that wraps to 0 after the 8th rise; on the 8th rise the assembled byte is pushed to the rx buffer.
REQ-019 SHALL assert rx_valid exactly SYNC_STAGES+2 clocks after the 8th SCK rise reaches the first synchronizer flop.
REQ-020 SHALL, on a push while the rx buffer is full, drop the new byte, keep the stored data and pulse rx_overrun; a push and pop on the same clock at full SHALL both succeed with no overrun.
REQ-021 SHALL, on SS rising mid-byte, discard the partial rx byte, clear the bit counter and discard the tx shifter contents; the hold register is untouched and no flag pulses.
REQ-022 SHALL treat SCK edges while SS is high as no-ops.
REQ-023 SHALL set busy from the synchronized SS fall until the synchronized SS rise.

Reset
REQ-024 SHALL, while reset is 1, force io_MISO=0, tx_ready=1, rx_valid=0, rx_data=0x00, rx_overrun=0, tx_underrun=0 and busy=0, and empty all buffers and counters.
REQ-025 SHALL, after reset deasserts with SS low (reset mid-frame), ignore SCK until the synchronized SS is seen high, so the next frame starts byte-aligned.

Configuration
REQ-026 SHALL use macro SPI_SLAVE_RXFIFO_EN: when defined, the rx buffer is a 4-entry FIFO; rx_data shows the head entry and rx_valid means non-empty.
REQ-027 SHALL, without SPI_SLAVE_RXFIFO_EN, use a single rx register; full means rx_valid=1. Behaviour at the ports is otherwise identical.

Verification
REQ-028 SHALL cover: hold=0xA5 preloaded, master sends 0x3C -> MISO bits 10100101, rx_data=0x3C, rx_valid after SYNC_STAGES+2 clocks.
REQ-029 SHALL cover: 2-byte frame with hold empty before byte 2 -> byte 2 returns 0xFF and tx_underrun pulses once.
REQ-030 SHALL cover: rx_ready=0 while 2 bytes arrive (no FIFO), or 5 bytes arrive (FIFO) -> rx_overrun pulses once and first-stored data is retained.
REQ-031 SHALL cover: SS raised after 5 bits, then full frame 0x81 -> rx_data=0x81, no flag pulses, hold byte still sent.
REQ-032 SHALL cover: reset pulsed after bit 3 with SS held low -> SCK ignored until SS high; next frame of 0x55 is received correctly.
REQ-033 SHALL cover: FIFO full, push and pop on the same clock -> no rx_overrun and occupancy stays 4.
